// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_arbiter
// Brief    : Two-requester arbiter for a single-port synchronous instruction
//            ROM. The CPU fetch port wins by default. A starvation counter
//            forces a grant to the auxiliary reader after STARVE_MAX
//            consecutive denials. The ROM returns data one cycle after the
//            address is presented, and that data is steered to whichever
//            requester owned the previous cycle.
// Revision : 1.0 - initial release
// ============================================================================
module imem_arbiter #(
  parameter int ADDR_W     = 30,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_stall,
  output logic              cpu_valid,
  output logic [DATA_W-1:0] cpu_inst,
  input  logic              aux_req,
  input  logic [ADDR_W-1:0] aux_addr,
  output logic              aux_ack,
  output logic              aux_valid,
  output logic [DATA_W-1:0] aux_data,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_inst
);

  localparam int                 CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]   C_STARVE_LIM = CNT_W'(STARVE_MAX);

  // Owner of the ROM read that is returning data in the current cycle.
  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_CPU  = 2'd1,
    ST_AUX  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_starved;
  logic             w_grant_aux;
  logic             w_grant_cpu;

  // Grant decision: the CPU wins unless aux has been denied long enough.
  always_comb begin
    w_starved   = (r_starve_cnt == C_STARVE_LIM);
    w_grant_aux = aux_req & (~cpu_req | w_starved);
    w_grant_cpu = cpu_req & ~w_grant_aux;
  end

  // Return-owner register; a grant made while in reset is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_NONE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next owner, ROM address mux, handshakes and return-data steering.
  always_comb begin
    w_state_nxt = ST_NONE;
    mem_addr    = cpu_addr;
    cpu_stall   = 1'b0;
    aux_ack     = 1'b0;
    cpu_valid   = 1'b0;
    cpu_inst    = '0;
    aux_valid   = 1'b0;
    aux_data    = '0;

    if (w_grant_aux) begin
      w_state_nxt = ST_AUX;
    end else if (w_grant_cpu) begin
      w_state_nxt = ST_CPU;
    end

    // When idle the CPU address is still presented; the speculative read
    // is harmless because no owner will claim the returned word.
    if (rst) begin
      mem_addr = '0;
    end else begin
      if (w_grant_aux) begin
        mem_addr = aux_addr;
      end
      cpu_stall = cpu_req & w_grant_aux;
      aux_ack   = w_grant_aux;
    end

    case (r_state)
      ST_CPU: begin
        cpu_valid = 1'b1;
        cpu_inst  = mem_inst;
      end
      ST_AUX: begin
        aux_valid = 1'b1;
        aux_data  = mem_inst;
      end
      default: begin
        cpu_valid = 1'b0;
        aux_valid = 1'b0;
      end
    endcase
  end

  // Consecutive-denial counter for aux; clears on grant or abandon, saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (w_grant_aux || !aux_req) begin
      r_starve_cnt <= '0;
    end else if (!w_starved) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire
